// File: rtl/mult8_seq_ctrl.sv
// Sequenced 8x8 unsigned multiplier: one shared 4x4 partial-product unit stepped over four cycles.
// Optional build macro MULT8_SEQ_EARLY_EXIT_EN: a zero operand finishes the operation immediately.
module mult8_seq_ctrl #(
    parameter bit DONE_PULSE = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Start,
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic       Busy,
    output logic       Done,
    output logic [7:0] Result,
    output logic       Overflow
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PP0,
        S_PP1,
        S_PP2,
        S_PP3,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [15:0] acc_q, acc_d;
    logic [7:0]  result_q, result_d;
    logic        overflow_q, overflow_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [3:0]  pp_x, pp_y;
    logic [7:0]  pp;
    logic [15:0] pp_shifted;
    logic        accept;
`ifdef MULT8_SEQ_EARLY_EXIT_EN
    logic        zero_op;
    assign zero_op = (A == 8'h00) || (B == 8'h00);
`endif

    assign accept = Start && ((state_q == S_IDLE) || (state_q == S_DONE));

    // Shared 4x4 unit: the current step picks the operand nibbles and the product alignment.
    always_comb begin
        pp_x       = a_q[3:0];
        pp_y       = b_q[3:0];
        pp_shifted = 16'h0000;
        case (state_q)
            S_PP1: pp_y = b_q[7:4];
            S_PP2: pp_x = a_q[7:4];
            S_PP3: begin
                pp_x = a_q[7:4];
                pp_y = b_q[7:4];
            end
            default: ;
        endcase
        pp = {4'h0, pp_x} * {4'h0, pp_y};
        case (state_q)
            S_PP0:        pp_shifted = {8'h00, pp};
            S_PP1, S_PP2: pp_shifted = {4'h0, pp, 4'h0};
            S_PP3:        pp_shifted = {pp, 8'h00};
            default:      pp_shifted = 16'h0000;
        endcase
    end

    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    a_d     = A;
                    b_d     = B;
                    acc_d   = 16'h0000;
                    state_d = S_PP0;
`ifdef MULT8_SEQ_EARLY_EXIT_EN
                    if (zero_op) begin
                        state_d    = S_DONE;
                        result_d   = 8'h00;
                        overflow_d = 1'b0;
                    end
`endif
                end else if ((state_q == S_DONE) && DONE_PULSE) begin
                    state_d = S_IDLE;
                end
            end
            S_PP0: begin
                acc_d   = acc_q + pp_shifted;
                state_d = S_PP1;
            end
            S_PP1: begin
                acc_d   = acc_q + pp_shifted;
                state_d = S_PP2;
            end
            S_PP2: begin
                acc_d   = acc_q + pp_shifted;
                state_d = S_PP3;
            end
            S_PP3: begin
                acc_d      = acc_q + pp_shifted;
                state_d    = S_DONE;
                result_d   = acc_d[7:0];
                overflow_d = |acc_d[15:8];
            end
            default: state_d = S_IDLE;
        endcase

        // Status flags decode the upcoming state so they are registered yet aligned with it.
        busy_d = (state_d == S_PP0) || (state_d == S_PP1) ||
                 (state_d == S_PP2) || (state_d == S_PP3);
        done_d = (state_d == S_DONE);
    end

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            a_q        <= 8'h00;
            b_q        <= 8'h00;
            acc_q      <= 16'h0000;
            result_q   <= 8'h00;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Result   = result_q;
    assign Overflow = overflow_q;

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Self-checking bench for mult8_seq_ctrl: vector table, random operands against a*b, handshake corners.
module tb_mult8_seq_ctrl;

`ifdef MULT8_SEQ_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a_in = 8'h00;
    logic [7:0] b_in = 8'h00;
    logic       busy, done, overflow;
    logic [7:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    mult8_seq_ctrl u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Start    (start),
        .A        (a_in),
        .B        (b_in),
        .Busy     (busy),
        .Done     (done),
        .Result   (result),
        .Overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] result;
        logic       ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Reference: the full product by plain arithmetic; {overflow, low byte}.
    function automatic logic [8:0] ref_mult(input logic [7:0] a, input logic [7:0] b);
        int p;
        p = int'(a) * int'(b);
        return {p > 255, p[7:0]};
    endfunction

    function automatic int op_latency(input logic [7:0] a, input logic [7:0] b);
        return (EARLY && (a == 8'h00 || b == 8'h00)) ? 1 : 5;
    endfunction

    // One operation: Start pulsed for a single edge, operands scrambled while it runs.
    task automatic do_op(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_r, input logic exp_o);
        int lat;
        lat = op_latency(a, b);
        @(negedge clk);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            start = 1'b0;
            a_in  = 8'($urandom);
            b_in  = 8'($urandom);
            if (k < lat) begin
                check({name, " busy"}, 16'({busy, done}), 16'(2'b10));
            end else begin
                check({name, " done"}, 16'({busy, done}), 16'(2'b01));
                check({name, " result"}, 16'(result), 16'(exp_r));
                check({name, " ovf"}, 16'(overflow), 16'(exp_o));
            end
        end
        @(negedge clk);
        check({name, " done pulse"}, 16'(done), 16'd0);
    endtask

    task automatic idle_check(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check(name, 16'({busy, done}), 16'(2'b00));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] m;
        logic [7:0] ra, rb;
        logic [7:0] ba[4];
        logic [7:0] bb[4];
        int         n_done, first_done;

        vecs[0] = '{8'd12,  8'd11,  8'h84, 1'b0};
        vecs[1] = '{8'd15,  8'd17,  8'hFF, 1'b0};
        vecs[2] = '{8'd16,  8'd16,  8'h00, 1'b1};
        vecs[3] = '{8'd255, 8'd255, 8'h01, 1'b1};
        vecs[4] = '{8'd0,   8'd200, 8'h00, 1'b0};
        vecs[5] = '{8'd1,   8'd255, 8'hFF, 1'b0};
        vecs[6] = '{8'd128, 8'd2,   8'h00, 1'b1};
        vecs[7] = '{8'd200, 8'd0,   8'h00, 1'b0};

        // Power-on reset, asserted between clock edges.
        #1 rst_n = 1'b0;
        #2 check("reset outputs", 16'({busy, done, result, overflow}), 16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle_check("idle after reset", 10);

        for (int i = 0; i < 8; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].result, vecs[i].ovf);
        end

        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom);
            rb = (i % 7 == 3) ? 8'h00 : 8'($urandom);
            m  = ref_mult(ra, rb);
            do_op($sformatf("rand%0d", i), ra, rb, m[7:0], m[8]);
        end

        // A second Start while busy is ignored: one Done, first operands' product.
        @(negedge clk);
        start = 1'b1;
        a_in  = 8'd3;
        b_in  = 8'd5;
        n_done = 0;
        first_done = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            start = (k == 2);
            if (k == 2) begin
                a_in = 8'd9;
                b_in = 8'd9;
            end
            if (done) begin
                n_done++;
                if (first_done == 0) first_done = k;
            end
            if (k == 5) check("busy start result", 16'(result), 16'h000F);
        end
        check("busy start done count", 16'(n_done), 16'd1);
        check("busy start done cycle", 16'(first_done), 16'd5);

        // Start held high: a new operation every 5 cycles.
        for (int i = 0; i < 4; i++) begin
            ba[i] = 8'($urandom_range(1, 255));
            bb[i] = 8'($urandom_range(1, 255));
        end
        @(negedge clk);
        start = 1'b1;
        a_in  = ba[0];
        b_in  = bb[0];
        for (int i = 0; i < 4; i++) begin
            m = ref_mult(ba[i], bb[i]);
            for (int k = 1; k <= 5; k++) begin
                @(negedge clk);
                if (k == 1) begin
                    if (i < 3) begin
                        a_in = ba[i + 1];
                        b_in = bb[i + 1];
                    end else begin
                        start = 1'b0;
                    end
                end
                if (k < 5) begin
                    check($sformatf("b2b%0d busy", i), 16'({busy, done}), 16'(2'b10));
                end else begin
                    check($sformatf("b2b%0d done", i), 16'({busy, done}), 16'(2'b01));
                    check($sformatf("b2b%0d result", i), 16'(result), 16'(m[7:0]));
                    check($sformatf("b2b%0d ovf", i), 16'(overflow), 16'(m[8]));
                end
            end
        end
        @(negedge clk);
        check("b2b end idle", 16'({busy, done}), 16'(2'b00));

        // Reset mid-operation aborts it; a stale non-zero Result must clear at once.
        do_op("pre abort", 8'd12, 8'd11, 8'h84, 1'b0);
        @(negedge clk);
        start = 1'b1;
        a_in  = 8'd200;
        b_in  = 8'd100;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1 check("abort outputs", 16'({busy, done, result, overflow}), 16'h0000);
        @(negedge clk);
        check("abort held", 16'({busy, done, result, overflow}), 16'h0000);
        rst_n = 1'b1;
        idle_check("no done after abort", 10);
        do_op("post abort", 8'd7, 8'd9, 8'h3F, 1'b0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
